// File: rtl/sym_serializer_pkg.sv
// Shared types and sizing for the serial symbol link (transmitter and receiver side).
// Both ends use calc_syms so that the MSB-side zero-padding rule is the same everywhere.
package sym_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SYM_W  = 3;

  function automatic int calc_syms(input int data_w, input int sym_w);
    return (data_w + sym_w - 1) / sym_w;
  endfunction

endpackage

// File: rtl/sym_serializer_tx.sv
// Parallel-to-serial symbol transmitter with per-word MSB/LSB-first order.
// Optional trailing even-parity symbol when SYM_SERIALIZER_PARITY_EN is defined.
module sym_serializer_tx
  import sym_serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYM_W  = DEF_SYM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] par_data,
  input  logic              par_valid,
  output logic              par_ready,
  input  logic              msb_first,
  output logic [SYM_W-1:0]  ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam int SYMS  = calc_syms(DATA_W, SYM_W);
  localparam int PAD_W = SYMS * SYM_W;
  localparam int CNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS - 1);
`ifdef SYM_SERIALIZER_PARITY_EN
  // The parity symbol carries the last marker, never a data symbol.
  localparam logic LAST_ON_DATA = 1'b0;
`else
  localparam logic LAST_ON_DATA = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               msb_q, msb_d;
  logic               par_ready_q, par_ready_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic               busy_q, busy_d;
  logic [SYM_W-1:0]   ser_data_q, ser_data_d;
  logic [PAD_W-1:0]   padded_s;
  logic [PAD_W-1:0]   shifted_s;
`ifdef SYM_SERIALIZER_PARITY_EN
  logic               parity_q, parity_d;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  // The symbol on the wire is always the end of the register facing the shift direction.
  function automatic logic [SYM_W-1:0] front_sym(input logic [PAD_W-1:0] w, input logic msb);
    if (msb) begin
      return w[PAD_W-1 -: SYM_W];
    end else begin
      return w[SYM_W-1:0];
    end
  endfunction

  assign padded_s  = PAD_W'(par_data);
  assign shifted_s = msb_q ? (shreg_q << SYM_W) : (shreg_q >> SYM_W);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    msb_d       = msb_q;
    par_ready_d = par_ready_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
    busy_d      = busy_q;
    ser_data_d  = ser_data_q;
`ifdef SYM_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (par_valid) begin
          state_d     = SEND;
          shreg_d     = padded_s;
          msb_d       = msb_first;
          cnt_d       = CNT_W'(0);
          par_ready_d = 1'b0;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
          ser_data_d  = front_sym(padded_s, msb_first);
          ser_last_d  = LAST_ON_DATA & (LAST_CNT == CNT_W'(0));
`ifdef SYM_SERIALIZER_PARITY_EN
          parity_d    = even_parity(par_data);
`endif
        end else begin
          par_ready_d = 1'b1;
          ser_valid_d = 1'b0;
        end
      end
      SEND: begin
        if (ser_ready) begin
          if (cnt_q == LAST_CNT) begin
`ifdef SYM_SERIALIZER_PARITY_EN
            state_d    = PARITY;
            ser_data_d = SYM_W'(parity_q);
            ser_last_d = 1'b1;
`else
            state_d     = IDLE;
            shreg_d     = '0;
            cnt_d       = CNT_W'(0);
            par_ready_d = 1'b1;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
            busy_d      = 1'b0;
            ser_data_d  = SYM_W'(0);
`endif
          end else begin
            shreg_d    = shifted_s;
            cnt_d      = cnt_q + CNT_W'(1);
            ser_data_d = front_sym(shifted_s, msb_q);
            ser_last_d = LAST_ON_DATA & ((cnt_q + CNT_W'(1)) == LAST_CNT);
          end
        end else begin
          state_d = SEND;
        end
      end
`ifdef SYM_SERIALIZER_PARITY_EN
      PARITY: begin
        if (ser_ready) begin
          state_d     = IDLE;
          shreg_d     = '0;
          cnt_d       = CNT_W'(0);
          par_ready_d = 1'b1;
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
          busy_d      = 1'b0;
          ser_data_d  = SYM_W'(0);
        end else begin
          state_d = PARITY;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        shreg_d     = '0;
        cnt_d       = CNT_W'(0);
        par_ready_d = 1'b1;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = 1'b0;
        ser_data_d  = SYM_W'(0);
      end
    endcase
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= CNT_W'(0);
      msb_q       <= 1'b0;
      par_ready_q <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      ser_data_q  <= SYM_W'(0);
`ifdef SYM_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      msb_q       <= msb_d;
      par_ready_q <= par_ready_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      ser_data_q  <= ser_data_d;
`ifdef SYM_SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign par_ready = par_ready_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;
  assign ser_data  = ser_data_q;

endmodule
